iurt_wb_master: RTL and testbench
=================================

IURT_WB_MASTER -- requirements
Module: iurt_wb_master

Interface
REQ-001 Parameter POLL_INTERVAL, default 16: idle cycles (ce-qualified) between status polls; legal range 1..65535.
REQ-002 Parameter ACK_TIMEOUT, default 255: ce-qualified cycles to wait for ack_i before abandoning a cycle; legal range 1..65535.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  reset, asynchronous assert, active-low.
REQ-005 ce  in  1  clock enable; when low, all state, counters and outputs hold.
REQ-006 cyc_o, stb_o, we_o  out  1 each  Wishbone classic master controls.
REQ-007 adr_o  out  [2:2]  0 = data register, 1 = status/control register.
REQ-008 dat_o  out  32  write data; dat_i  in  32  read data; ack_i  in  1  slave acknowledge.
REQ-009 tx_valid  in  1, tx_data  in  8, tx_ready  out  1  byte stream toward slave transmit register.
REQ-010 rx_valid  out  1, rx_data  out  8, rx_ready  in  1  byte stream from slave receive register.
REQ-011 brk_req  in  1 (pulse), brk_val  in  1  request to write break-enable bit.
REQ-012 err  out  1  sticky ack-timeout flag; err_clr  in  1  clears it.

Function
REQ-013 Slave map: read adr 1 = status, non-consuming; read adr 0 = status plus byte consume; write adr 0 = tx byte in dat[7:0], slave stalls ack while its tx buffer is full; write adr 1 = break enable in dat[0].
REQ-014 Status word: bit 9 = slave TxReady, bit 8 = slave rx valid, bits 7:0 = rx byte; the block ignores bits 31:10.
REQ-015 TX holding register: one byte; tx_ready = empty; tx_valid & tx_ready loads it; it empties in the cycle the data write is acked.
REQ-016 RX output register: one byte; rx_valid is set with rx_data on the data-read ack; it clears on rx_valid & rx_ready.
REQ-017 FSM states: IDLE, WAIT, STAT, RD_DATA, WR_DATA, WR_CTRL.
REQ-018 IDLE evaluates requests in strict priority: pending brk -> WR_CTRL; else WAIT.
REQ-019 WAIT counts POLL_INTERVAL cycles, then goes to STAT; a pending brk request aborts WAIT and goes to WR_CTRL.
REQ-020 STAT issues a read at adr 1. On ack, priority is: bit8=1 & rx register empty -> RD_DATA; else bit9=1 & tx register full -> WR_DATA; else IDLE.
REQ-021 RD_DATA issues a read at adr 0; on ack it captures dat_i[7:0] into the rx register, then goes to IDLE.
REQ-022 WR_DATA issues a write at adr 0 with dat_o = {24'b0, byte}; on ack it goes to IDLE.
REQ-023 WR_CTRL issues a write at adr 1 with dat_o = {31'b0, brk_val latched}; on ack it clears the pending flag, then goes to IDLE.
REQ-024 brk_req sets a pending flag and latches brk_val; a new brk_req during a pending request overwrites the latched value.
REQ-025 Bus cycles: cyc_o = stb_o = 1 from the first cycle of the access state until and including the ack cycle; both drop the cycle after ack; there is at least one idle bus cycle between accesses.
REQ-026 Ack timeout: a timer counts ack wait cycles; at ACK_TIMEOUT without ack, cyc/stb drop, err sets, the FSM returns to IDLE, and tx/rx/brk state is unchanged (retry on next poll).
REQ-027 err_clr has priority over a simultaneous err set: the set is lost.
REQ-028 tx load and tx ack in the same cycle cannot occur: tx_ready is low while full.
REQ-029 rx_ready asserted in the same cycle as an rx capture cannot occur, because RD_DATA requires the rx register empty.

Reset
REQ-030 rst low asynchronously forces: state IDLE, cyc_o/stb_o/we_o = 0, adr_o = 0, dat_o = 0, tx empty (tx_ready = 1), rx_valid = 0, rx_data = 0, err = 0, brk pending = 0, counters = 0.
REQ-031 Reset mid-access abandons the bus cycle immediately; no retry of the lost byte occurs.

Structure
REQ-032 Shared package iurt_pkg holds: FSM state enum, ADR_DATA = 0, ADR_CTRL = 1, STAT_RXVALID_BIT = 8, STAT_TXREADY_BIT = 9.
REQ-033 One sub-module, iurt_wb_timer, provides the loadable down-counter used for both the WAIT interval and the ack timeout.

Verification
REQ-034 Slave rx byte 0x5A, POLL_INTERVAL = 4 -> status read adr 1, then read adr 0, then rx_valid with rx_data = 0x5A; no further data read until rx_ready.
REQ-035 tx_valid with 0xC3 while slave TxReady = 1 -> next poll writes adr 0 with dat_o = 0x000000C3; tx_ready returns to 1 on ack.
REQ-036 Slave rx valid and master tx full in the same poll -> RD_DATA runs before WR_DATA, on the following poll.
REQ-037 brk_req with brk_val = 0 during WAIT -> write at adr 1 with dat_o = 0x00000000 before the next status read.
REQ-038 ack_i withheld with ACK_TIMEOUT = 8 -> cyc_o drops after 8 cycles and err = 1; err_clr -> err = 0; the tx byte is still pending and is retried.
REQ-039 rst low during WR_DATA -> cyc_o = 0 in the same cycle, tx_ready = 1, rx_valid = 0.

Source files
------------

// File: rtl/iurt_pkg.sv
// Shared types and constants for the IURT Wishbone master.
package iurt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_STAT,
    ST_RD_DATA,
    ST_WR_DATA,
    ST_WR_CTRL
  } state_t;

  localparam logic ADR_DATA = 1'b0;
  localparam logic ADR_CTRL = 1'b1;

  localparam int STAT_RXVALID_BIT = 8;
  localparam int STAT_TXREADY_BIT = 9;

  // States that own the bus while they are active.
  function automatic logic is_access(input state_t s);
    return (s == ST_STAT) || (s == ST_RD_DATA) || (s == ST_WR_DATA) || (s == ST_WR_CTRL);
  endfunction

endpackage

// File: rtl/iurt_wb_timer.sv
// Loadable down-counter shared by the poll interval and the ack timeout.
module iurt_wb_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        dec,
  output logic        last
);

  logic [15:0] count;

  // Load has priority over decrement; the count saturates at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (ce) begin
      if (load) begin
        count <= load_val;
      end else if (dec && (count != 16'd0)) begin
        count <= count - 16'd1;
      end
    end
  end

  assign last = (count <= 16'd1);

endmodule

// File: rtl/iurt_wb_master.sv
// Wishbone classic master that polls a UART-like slave and moves bytes.
module iurt_wb_master
  import iurt_pkg::*;
#(
  parameter int unsigned POLL_INTERVAL = 16,
  parameter int unsigned ACK_TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [2:2]  adr_o,
  output logic [31:0] dat_o,
  input  logic [31:0] dat_i,
  input  logic        ack_i,
  input  logic        tx_valid,
  input  logic [7:0]  tx_data,
  output logic        tx_ready,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  input  logic        rx_ready,
  input  logic        brk_req,
  input  logic        brk_val,
  output logic        err,
  input  logic        err_clr
);

  localparam logic [15:0] POLL_LOAD = 16'(POLL_INTERVAL);
  localparam logic [15:0] ACK_LOAD  = 16'(ACK_TIMEOUT);

  state_t      state;
  logic        tx_full;
  logic [7:0]  tx_byte;
  logic        brk_pend;
  logic        brk_q;
  logic        tmr_load;
  logic [15:0] tmr_load_val;
  logic        tmr_dec;
  logic        tmr_last;
  logic        bus_ack;
  logic        ack_timeout;
  logic        rd_data_ack;
  logic        wr_data_ack;
  logic        wr_ctrl_ack;
  logic        stat_rx;
  logic        stat_tx;
  logic        unused_dat;

  assign tx_ready    = ~tx_full;
  assign bus_ack     = cyc_o & ack_i;
  assign ack_timeout = is_access(state) & cyc_o & ~ack_i & tmr_last;
  assign rd_data_ack = (state == ST_RD_DATA) & bus_ack;
  assign wr_data_ack = (state == ST_WR_DATA) & bus_ack;
  assign wr_ctrl_ack = (state == ST_WR_CTRL) & bus_ack;
  assign stat_rx     = dat_i[STAT_RXVALID_BIT];
  assign stat_tx     = dat_i[STAT_TXREADY_BIT];
  assign unused_dat  = ^dat_i[31:10];

  iurt_wb_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .ce       (ce),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .last     (tmr_last)
  );

  // Timer is loaded with the poll interval on entering WAIT and with the ack limit whenever a bus cycle starts.
  always_comb begin
    tmr_load     = 1'b0;
    tmr_load_val = ACK_LOAD;
    tmr_dec      = 1'b0;
    case (state)
      ST_IDLE: begin
        tmr_load = 1'b1;
        if (!brk_pend) tmr_load_val = POLL_LOAD;
      end
      ST_WAIT: begin
        if (brk_pend || tmr_last) tmr_load = 1'b1;
        else                      tmr_dec  = 1'b1;
      end
      default: begin
        if (!cyc_o)      tmr_load = 1'b1;
        else if (!ack_i) tmr_dec  = 1'b1;
      end
    endcase
  end

  // Poll sequencer; bus outputs are registered and set up on the transition into each access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cyc_o <= 1'b0;
      stb_o <= 1'b0;
      we_o  <= 1'b0;
      adr_o <= ADR_DATA;
      dat_o <= '0;
    end else if (ce) begin
      case (state)
        ST_IDLE, ST_WAIT: begin
          if (brk_pend) begin
            state <= ST_WR_CTRL;
            cyc_o <= 1'b1;
            stb_o <= 1'b1;
            we_o  <= 1'b1;
            adr_o <= ADR_CTRL;
            dat_o <= {31'b0, brk_q};
          end else if (state == ST_IDLE) begin
            state <= ST_WAIT;
          end else if (tmr_last) begin
            state <= ST_STAT;
            cyc_o <= 1'b1;
            stb_o <= 1'b1;
            we_o  <= 1'b0;
            adr_o <= ADR_CTRL;
          end
        end
        default: begin
          if (!cyc_o) begin
            // Follow-on access after STAT: one idle bus cycle has passed, start it now.
            cyc_o <= 1'b1;
            stb_o <= 1'b1;
          end else if (ack_i) begin
            cyc_o <= 1'b0;
            stb_o <= 1'b0;
            we_o  <= 1'b0;
            state <= ST_IDLE;
            if (state == ST_STAT) begin
              if (stat_rx && !rx_valid) begin
                state <= ST_RD_DATA;
                adr_o <= ADR_DATA;
              end else if (stat_tx && tx_full) begin
                state <= ST_WR_DATA;
                we_o  <= 1'b1;
                adr_o <= ADR_DATA;
                dat_o <= {24'b0, tx_byte};
              end
            end
          end else if (tmr_last) begin
            cyc_o <= 1'b0;
            stb_o <= 1'b0;
            we_o  <= 1'b0;
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // TX holding register: loads only while empty, empties when the data write is acked.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_full <= 1'b0;
      tx_byte <= '0;
    end else if (ce) begin
      if (wr_data_ack) begin
        tx_full <= 1'b0;
      end else if (tx_valid && !tx_full) begin
        tx_full <= 1'b1;
        tx_byte <= tx_data;
      end
    end
  end

  // RX output register: captured on the data-read ack, released by the consumer handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else if (ce) begin
      if (rd_data_ack) begin
        rx_valid <= 1'b1;
        rx_data  <= dat_i[7:0];
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  // Break request: a fresh request overwrites the latched value and keeps the request pending.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      brk_pend <= 1'b0;
      brk_q    <= 1'b0;
    end else if (ce) begin
      if (brk_req) begin
        brk_pend <= 1'b1;
        brk_q    <= brk_val;
      end else if (wr_ctrl_ack) begin
        brk_pend <= 1'b0;
      end
    end
  end

  // Sticky timeout flag; a clear in the same cycle as a timeout wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (ce) begin
      if (err_clr)          err <= 1'b0;
      else if (ack_timeout) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_iurt_wb_master.sv
// Scoreboard bench for iurt_wb_master with a small UART-like slave model.
module tb_iurt_wb_master;

  localparam int unsigned POLL = 4;
  localparam int unsigned TMO  = 8;

  typedef struct {
    logic        we;
    logic        adr;
    logic [31:0] dat;
  } bus_exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b1;
  logic        cyc_o;
  logic        stb_o;
  logic        we_o;
  logic [2:2]  adr_o;
  logic [31:0] dat_o;
  logic [31:0] dat_i = '0;
  logic        ack_i = 1'b0;
  logic        tx_valid = 1'b0;
  logic [7:0]  tx_data = '0;
  logic        tx_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready = 1'b0;
  logic        brk_req = 1'b0;
  logic        brk_val = 1'b0;
  logic        err;
  logic        err_clr = 1'b0;

  logic        s_tx_ready = 1'b0;
  logic [7:0]  s_rx_byte = '0;
  int          rx_offer = 0;
  int          rx_taken = 0;
  logic        s_rx_valid;
  logic        hold_wr_ack = 1'b0;
  logic        strict_ctrl = 1'b0;

  int          checks = 0;
  int          errors = 0;

  bus_exp_t    exp_bus[$];
  logic [7:0]  exp_rx[$];

  assign s_rx_valid = (rx_offer != rx_taken);

  iurt_wb_master #(.POLL_INTERVAL(POLL), .ACK_TIMEOUT(TMO)) dut (
    .clk      (clk),
    .rst      (rst),
    .ce       (ce),
    .cyc_o    (cyc_o),
    .stb_o    (stb_o),
    .we_o     (we_o),
    .adr_o    (adr_o),
    .dat_o    (dat_o),
    .dat_i    (dat_i),
    .ack_i    (ack_i),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .brk_req  (brk_req),
    .brk_val  (brk_val),
    .err      (err),
    .err_clr  (err_clr)
  );

  always #5 clk = ~clk;

  // Slave: acks one cycle into each access, returns a status snapshot, consumes rx on data reads.
  always @(negedge clk) begin
    if (ack_i) begin
      ack_i = 1'b0;
    end else if (cyc_o && stb_o && !(hold_wr_ack && we_o)) begin
      dat_i = {22'b0, s_tx_ready, s_rx_valid, s_rx_byte};
      ack_i = 1'b1;
      if (!we_o && adr_o == 1'b0) rx_taken = rx_offer;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  // Bus monitor: every acked non-status access must match the head of the expected queue.
  always @(negedge clk) begin
    bus_exp_t e;
    #1;
    if (cyc_o && stb_o && ack_i) begin
      if (!we_o && adr_o == 1'b1) begin
        if (strict_ctrl) begin
          checks++;
          errors++;
          $display("[TB] FAIL ctrl_before_stat actual=status_read required=ctrl_write");
          strict_ctrl = 1'b0;
        end
      end else if (exp_bus.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_access actual=we%0b_adr%0b_dat%h required=none", we_o, adr_o, dat_o);
      end else begin
        e = exp_bus.pop_front();
        checkOutput("bus_we", {31'b0, we_o}, {31'b0, e.we});
        checkOutput("bus_adr", {31'b0, adr_o}, {31'b0, e.adr});
        if (e.we) checkOutput("bus_dat", dat_o, e.dat);
        if (e.we && e.adr) strict_ctrl = 1'b0;
      end
    end
  end

  // RX monitor: each consumed byte must match the next expected byte.
  always @(negedge clk) begin
    logic [7:0] b;
    #2;
    if (rx_valid && rx_ready) begin
      if (exp_rx.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_rx actual=%h required=none", rx_data);
      end else begin
        b = exp_rx.pop_front();
        checkOutput("rx_data", {24'b0, rx_data}, {24'b0, b});
      end
    end
  end

  task automatic pushBus(input logic we, input logic adr, input logic [31:0] dat);
    bus_exp_t e;
    e.we  = we;
    e.adr = adr;
    e.dat = dat;
    exp_bus.push_back(e);
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = b;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic offerRx(input logic [7:0] b);
    s_rx_byte = b;
    rx_offer++;
  endtask

  task automatic consumeRx();
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic pulseBrk(input logic v);
    @(negedge clk);
    brk_req = 1'b1;
    brk_val = v;
    @(negedge clk);
    brk_req = 1'b0;
  endtask

  task automatic waitTxReady(input logic v);
    int n = 0;
    while (tx_ready !== v && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (tx_ready !== v) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_tx_ready actual=%b required=%b", tx_ready, v);
    end
  endtask

  task automatic waitRxValid();
    int n = 0;
    while (rx_valid !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (rx_valid !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_rx_valid actual=%b required=1", rx_valid);
    end
  endtask

  task automatic waitWriteStart();
    int n = 0;
    while (!(cyc_o && we_o && adr_o == 1'b0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!(cyc_o && we_o && adr_o == 1'b0)) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_write_start actual=cyc%0b_we%0b required=cyc1_we1", cyc_o, we_o);
    end
  endtask

  task automatic waitStatusEnd();
    int n = 0;
    while (!(cyc_o && !we_o && adr_o == 1'b1) && n < 400) begin
      @(negedge clk);
      n++;
    end
    while (cyc_o && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_status_read actual=timeout required=status_read");
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    logic bad;

    // Reset values
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_cyc", {31'b0, cyc_o}, 32'd0);
    checkOutput("rst_stb", {31'b0, stb_o}, 32'd0);
    checkOutput("rst_we", {31'b0, we_o}, 32'd0);
    checkOutput("rst_adr", {31'b0, adr_o}, 32'd0);
    checkOutput("rst_dat", dat_o, 32'd0);
    checkOutput("rst_tx_ready", {31'b0, tx_ready}, 32'd1);
    checkOutput("rst_rx_valid", {31'b0, rx_valid}, 32'd0);
    checkOutput("rst_rx_data", {24'b0, rx_data}, 32'd0);
    checkOutput("rst_err", {31'b0, err}, 32'd0);
    rst = 1'b1;
    repeat (20) @(negedge clk);

    // RX byte 0x5A, then a second byte held off until the first is consumed
    pushBus(1'b0, 1'b0, 32'd0);
    exp_rx.push_back(8'h5A);
    offerRx(8'h5A);
    waitRxValid();
    checkOutput("rx_first_byte", {24'b0, rx_data}, 32'h5A);
    offerRx(8'h11);
    repeat (40) @(negedge clk);
    checkOutput("rx_hold_valid", {31'b0, rx_valid}, 32'd1);
    checkOutput("rx_hold_data", {24'b0, rx_data}, 32'h5A);
    pushBus(1'b0, 1'b0, 32'd0);
    exp_rx.push_back(8'h11);
    consumeRx();
    waitRxValid();
    consumeRx();

    // TX byte 0xC3 with slave ready
    s_tx_ready = 1'b1;
    pushBus(1'b1, 1'b0, 32'h0000_00C3);
    applyStimulus(8'hC3);
    checkOutput("tx_loaded", {31'b0, tx_ready}, 32'd0);
    waitTxReady(1'b1);
    checkOutput("tx_ready_after_ack", {31'b0, tx_ready}, 32'd1);

    // RX and TX both pending in one poll: read first, write on the next poll
    s_tx_ready = 1'b0;
    applyStimulus(8'hA5);
    repeat (20) @(negedge clk);
    checkOutput("tx_held_slave_busy", {31'b0, tx_ready}, 32'd0);
    pushBus(1'b0, 1'b0, 32'd0);
    pushBus(1'b1, 1'b0, 32'h0000_00A5);
    exp_rx.push_back(8'h7E);
    offerRx(8'h7E);
    s_tx_ready = 1'b1;
    waitTxReady(1'b1);
    waitRxValid();
    consumeRx();

    // Break requests issued during WAIT
    waitStatusEnd();
    @(negedge clk);
    pushBus(1'b1, 1'b1, 32'h0000_0000);
    strict_ctrl = 1'b1;
    pulseBrk(1'b0);
    repeat (30) @(negedge clk);
    waitStatusEnd();
    @(negedge clk);
    pushBus(1'b1, 1'b1, 32'h0000_0001);
    strict_ctrl = 1'b1;
    pulseBrk(1'b1);
    repeat (30) @(negedge clk);

    // Ack withheld on a data write: timeout, err, clear, retry
    hold_wr_ack = 1'b1;
    applyStimulus(8'h3C);
    waitWriteStart();
    n = 0;
    while (cyc_o && n < 50) begin
      n++;
      @(negedge clk);
    end
    checkOutput("timeout_cycles", n, TMO);
    checkOutput("timeout_err", {31'b0, err}, 32'd1);
    checkOutput("timeout_tx_pending", {31'b0, tx_ready}, 32'd0);
    pushBus(1'b1, 1'b0, 32'h0000_003C);
    hold_wr_ack = 1'b0;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checkOutput("err_cleared", {31'b0, err}, 32'd0);
    waitTxReady(1'b1);

    // err_clr held across a timeout: the set is lost
    hold_wr_ack = 1'b1;
    err_clr = 1'b1;
    applyStimulus(8'h81);
    waitWriteStart();
    n = 0;
    while (cyc_o && n < 50) begin
      n++;
      @(negedge clk);
    end
    checkOutput("clr_beats_set_err", {31'b0, err}, 32'd0);
    checkOutput("clr_tx_pending", {31'b0, tx_ready}, 32'd0);
    pushBus(1'b1, 1'b0, 32'h0000_0081);
    hold_wr_ack = 1'b0;
    err_clr = 1'b0;
    waitTxReady(1'b1);

    // Clock enable low: no load, no bus activity
    while (cyc_o) @(negedge clk);
    ce = 1'b0;
    tx_valid = 1'b1;
    tx_data = 8'h55;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cyc_o) bad = 1'b1;
    end
    tx_valid = 1'b0;
    ce = 1'b1;
    checkOutput("ce_low_no_cycle", {31'b0, bad}, 32'd0);
    checkOutput("ce_low_no_load", {31'b0, tx_ready}, 32'd1);
    repeat (20) @(negedge clk);

    // Reset in the middle of a data write
    pushBus(1'b0, 1'b0, 32'd0);
    offerRx(8'h42);
    waitRxValid();
    hold_wr_ack = 1'b1;
    applyStimulus(8'h99);
    waitWriteStart();
    rst = 1'b0;
    #1;
    checkOutput("midrst_cyc", {31'b0, cyc_o}, 32'd0);
    checkOutput("midrst_tx_ready", {31'b0, tx_ready}, 32'd1);
    checkOutput("midrst_rx_valid", {31'b0, rx_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    hold_wr_ack = 1'b0;
    repeat (60) @(negedge clk);

    checkOutput("bus_queue_empty", exp_bus.size(), 32'd0);
    checkOutput("rx_queue_empty", exp_rx.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
